mioc_fabric: RTL

//  Parametrised memory/IO interconnect between the MIPS data port and NUM_SLV slaves (RAM, IO, timer...).

---
 rtl/mioc_fabric.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mioc_fabric.sv
// mioc_fabric: decodes MIPS data-port accesses by base/mask and drives one of NUM_SLV slaves.
// Latency: zero-wait slave completes at request+2 cycles; unmapped access errors at request+1.
// Backpressure: memStall_o holds the CPU until DONE/ERR; slave waits are bounded by TIMEOUT.
// Optional MIOC_ERR_CAPTURE_EN adds sticky first-fault capture (errAddr_o/errValid_o/errClr_i).
module mioc_fabric #(
   parameter int                         NUM_SLV  = 2,
   parameter int                         ADDR_W   = 32,
   parameter int                         DATA_W   = 32,
   parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = {32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = {32'hF000_0000, 32'hF000_0000},
   parameter int                         TIMEOUT  = 16,
   parameter logic [DATA_W-1:0]          ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        memCe_i,
   input  logic                        memWr_i,
   input  logic [ADDR_W-1:0]           memAddr_i,
   input  logic [DATA_W-1:0]           wtData_i,
   output logic [DATA_W-1:0]           rdData_o,
   output logic                        memStall_o,
   output logic                        busErr_o,
   output logic [NUM_SLV-1:0]          slvCe_o,
   output logic                        slvWe_o,
   output logic [ADDR_W-1:0]           slvAddr_o,
   output logic [DATA_W-1:0]           slvWtData_o,
   input  logic [NUM_SLV*DATA_W-1:0]   slvRdData_i,
   input  logic [NUM_SLV-1:0]          slvReady_i
`ifdef MIOC_ERR_CAPTURE_EN
   ,
   output logic [ADDR_W-1:0]           errAddr_o,
   output logic                        errValid_o,
   input  logic                        errClr_i
`endif
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

   state_t              state_q, state_d;
   logic [NUM_SLV-1:0]  sel_q, sel_d;       // one-hot latched target
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [NUM_SLV-1:0]  hit;
   logic [DATA_W-1:0]   slv_rd;
   logic                tgt_rdy;

   // Address decode: scan downward so the lowest-index hit is the one left standing.
   always_comb begin
      hit = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((memAddr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            hit    = '0;
            hit[i] = 1'b1;
         end
      end
   end

   // Read-data mux and ready of the latched target; other slaves' ready is ignored.
   always_comb begin
      slv_rd = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_q[i]) slv_rd = slv_rd | slvRdData_i[i*DATA_W +: DATA_W];
      end
      tgt_rdy = |(slvReady_i & sel_q);
   end

   // Next-state and datapath update for the access FSM.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (memCe_i) begin
               if (|hit) begin
                  sel_d   = hit;
                  we_d    = memWr_i;
                  addr_d  = memAddr_i;
                  wdata_d = wtData_i;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  if (!memWr_i) rdata_d = ERR_DATA;
                  state_d = ERR;
               end
            end
         end
         ACCESS: begin
            if (tgt_rdy) begin
               if (!we_q) rdata_d = slv_rd;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               if (!we_q) rdata_d = ERR_DATA;
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign slvCe_o     = sel_q & {NUM_SLV{state_q == ACCESS}};
   assign slvWe_o     = we_q & (state_q == ACCESS);
   assign slvAddr_o   = addr_q;
   assign slvWtData_o = wdata_q;
   assign rdData_o    = rdata_q;
   assign busErr_o    = (state_q == ERR);
   assign memStall_o  = memCe_i & (state_q != DONE) & (state_q != ERR);

`ifdef MIOC_ERR_CAPTURE_EN
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              err_vld_q, err_vld_d;

   // First-fault capture: a new error beats a same-cycle clear; address frozen while valid.
   always_comb begin
      err_addr_d = err_addr_q;
      err_vld_d  = err_vld_q;
      if (state_d == ERR) begin
         if (!err_vld_q) err_addr_d = (state_q == IDLE) ? memAddr_i : addr_q;
         err_vld_d = 1'b1;
      end else if (errClr_i) begin
         err_vld_d = 1'b0;
      end
   end

   // Error capture registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_addr_q <= '0;
         err_vld_q  <= 1'b0;
      end else begin
         err_addr_q <= err_addr_d;
         err_vld_q  <= err_vld_d;
      end
   end

   assign errAddr_o  = err_addr_q;
   assign errValid_o = err_vld_q;
`endif

endmodule
